// File: rtl/lcd_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pixel_writer
// Purpose  : Subsamples a gated 640x480 RGB444 pixel stream 2:1 in each axis,
//            converts kept pixels to RGB565, buffers them in a small FIFO and
//            writes them to an 8080-style 8-bit write-only LCD bus. Also runs
//            the panel power-up sequence (reset, sleep-out, 16-bit colour
//            mode, display-on) and issues a memory-write command per frame.
// Ports    : clk_100      - single clock, rising edge
//            resetN       - synchronous active-low reset
//            pxl_en       - one-cycle pixel-valid strobe
//            pxl_x/pxl_y  - pixel column/row (11 bits)
//            red_in/green_in/blue_in - 4-bit colour levels
//            lcd_db       - LCD data bus
//            lcd_wr       - write strobe (active low, panel latches on rise)
//            lcd_d_c      - 0 = command byte, 1 = data byte
//            lcd_rd       - read strobe, tied high
//            lcd_reset    - panel reset, active low
//            init_done    - init sequence finished
//            overflow     - sticky: a kept pixel was dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module lcd_pixel_writer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int RST_CYC     = 1000000,
    parameter int WAKE_CYC    = 12000000
) (
    input  logic        clk_100,
    input  logic        resetN,
    input  logic        pxl_en,
    input  logic [10:0] pxl_x,
    input  logic [10:0] pxl_y,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic [7:0]  lcd_db,
    output logic        lcd_wr,
    output logic        lcd_d_c,
    output logic        lcd_rd,
    output logic        lcd_reset,
    output logic        init_done,
    output logic        overflow
);

    localparam int c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W     = c_PTR_W + 1;
    localparam int c_BYTE_CYC  = WR_LOW_CYC + WR_HIGH_CYC;
    localparam int c_BCNT_W    = (c_BYTE_CYC > 1) ? $clog2(c_BYTE_CYC) : 1;
    localparam int c_WAIT_MAX  = (RST_CYC > WAKE_CYC) ? RST_CYC : WAKE_CYC;
    localparam int c_WAIT_W    = $clog2(c_WAIT_MAX + 1);

    localparam logic [c_WAIT_W-1:0] c_RST_LAST  = c_WAIT_W'(RST_CYC - 1);
    localparam logic [c_WAIT_W-1:0] c_WAKE_LAST = c_WAIT_W'(WAKE_CYC - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [c_BCNT_W-1:0] c_LOW_LAST  = c_BCNT_W'(WR_LOW_CYC - 1);
    localparam logic [c_BCNT_W-1:0] c_BYTE_LAST = c_BCNT_W'(c_BYTE_CYC - 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_ONE  = c_BCNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_FULL_CNT  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);

    localparam logic [7:0] c_CMD_SLPOUT = 8'h11;
    localparam logic [7:0] c_CMD_COLMOD = 8'h3A;
    localparam logic [7:0] c_DAT_COLMOD = 8'h55;
    localparam logic [7:0] c_CMD_DISPON = 8'h29;
    localparam logic [7:0] c_CMD_RAMWR  = 8'h2C;

    localparam logic [3:0] c_ST_RST_LOW   = 4'd0;
    localparam logic [3:0] c_ST_RST_WAIT  = 4'd1;
    localparam logic [3:0] c_ST_SLPOUT    = 4'd2;
    localparam logic [3:0] c_ST_WAKE_WAIT = 4'd3;
    localparam logic [3:0] c_ST_COLMOD    = 4'd4;
    localparam logic [3:0] c_ST_COLDAT    = 4'd5;
    localparam logic [3:0] c_ST_DISPON    = 4'd6;
    localparam logic [3:0] c_ST_IDLE      = 4'd7;
    localparam logic [3:0] c_ST_RAMWR     = 4'd8;
    localparam logic [3:0] c_ST_PIX_HI    = 4'd9;
    localparam logic [3:0] c_ST_PIX_LO    = 4'd10;

    // ------------------------------------------------------------------
    // Pixel keep / conversion
    // ------------------------------------------------------------------
    logic        w_keep;
    logic        w_accept;
    logic        w_sof;
    logic [16:0] w_entry;

    assign w_keep   = pxl_en && (pxl_x < 11'd640) && (pxl_y < 11'd480) &&
                      !pxl_x[0] && !pxl_y[0];
    // Pixels before init completes are discarded without touching overflow.
    assign w_accept = w_keep && init_done;
    assign w_sof    = (pxl_x == 11'd0) && (pxl_y == 11'd0);
    // {sof, R5, G6, B5}: low bits replicate the MSBs to span full scale.
    assign w_entry  = {w_sof, red_in, red_in[3], green_in, green_in[3:2],
                       blue_in, blue_in[3]};

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    logic [16:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [16:0]        w_head;

    logic [3:0]          r_state;
    logic [c_BCNT_W-1:0] r_bcnt;
    logic [c_WAIT_W-1:0] r_wait;
    logic [15:0]         r_pix;

    // Full is judged on the pre-pop count, so a push on full is dropped
    // even when the FSM pops in the same cycle.
    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = w_accept && !w_full;
    assign w_head  = r_mem[r_rd_ptr];
    // Pop from IDLE, or directly at the end of a LO byte so pixels stream
    // back to back with no idle cycle between them.
    assign w_pop   = !w_empty &&
                     ((r_state == c_ST_IDLE) ||
                      ((r_state == c_ST_PIX_LO) && (r_bcnt == c_BYTE_LAST)));

    always_ff @(posedge clk_100) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk_100) begin
        if (!resetN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_accept && w_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Init / write FSM with registered bus outputs
    // ------------------------------------------------------------------
    assign lcd_rd = 1'b1;

    always_ff @(posedge clk_100) begin
        if (!resetN) begin
            r_state   <= c_ST_RST_LOW;
            r_wait    <= '0;
            r_bcnt    <= '0;
            r_pix     <= '0;
            lcd_reset <= 1'b0;
            lcd_wr    <= 1'b1;
            lcd_d_c   <= 1'b1;
            lcd_db    <= 8'h00;
            init_done <= 1'b0;
        end else begin
            case (r_state)
                c_ST_RST_LOW: begin
                    if (r_wait == c_RST_LAST) begin
                        r_state   <= c_ST_RST_WAIT;
                        r_wait    <= '0;
                        lcd_reset <= 1'b1;
                    end else begin
                        r_wait <= r_wait + c_WAIT_ONE;
                    end
                end
                c_ST_RST_WAIT, c_ST_WAKE_WAIT: begin
                    if ((r_wait == c_WAKE_LAST)) begin
                        r_bcnt  <= '0;
                        lcd_wr  <= 1'b0;
                        lcd_d_c <= 1'b0;
                        if (r_state == c_ST_RST_WAIT) begin
                            r_state <= c_ST_SLPOUT;
                            lcd_db  <= c_CMD_SLPOUT;
                        end else begin
                            r_state <= c_ST_COLMOD;
                            lcd_db  <= c_CMD_COLMOD;
                        end
                    end else begin
                        r_wait <= r_wait + c_WAIT_ONE;
                    end
                end
                c_ST_IDLE: begin
                    r_state <= c_ST_IDLE;
                end
                c_ST_SLPOUT, c_ST_COLMOD, c_ST_COLDAT, c_ST_DISPON,
                c_ST_RAMWR, c_ST_PIX_HI, c_ST_PIX_LO: begin
                    // Shared byte timing: low phase then high phase, with
                    // db/d_c held; the last cycle launches the next byte.
                    r_bcnt <= r_bcnt + c_BCNT_ONE;
                    if (r_bcnt == c_LOW_LAST) begin
                        lcd_wr <= 1'b1;
                    end
                    if (r_bcnt == c_BYTE_LAST) begin
                        r_bcnt <= '0;
                        case (r_state)
                            c_ST_SLPOUT: begin
                                r_state <= c_ST_WAKE_WAIT;
                                r_wait  <= '0;
                            end
                            c_ST_COLMOD: begin
                                r_state <= c_ST_COLDAT;
                                lcd_db  <= c_DAT_COLMOD;
                                lcd_d_c <= 1'b1;
                                lcd_wr  <= 1'b0;
                            end
                            c_ST_COLDAT: begin
                                r_state <= c_ST_DISPON;
                                lcd_db  <= c_CMD_DISPON;
                                lcd_d_c <= 1'b0;
                                lcd_wr  <= 1'b0;
                            end
                            c_ST_DISPON: begin
                                r_state   <= c_ST_IDLE;
                                init_done <= 1'b1;
                            end
                            c_ST_RAMWR: begin
                                r_state <= c_ST_PIX_HI;
                                lcd_db  <= r_pix[15:8];
                                lcd_d_c <= 1'b1;
                                lcd_wr  <= 1'b0;
                            end
                            c_ST_PIX_HI: begin
                                r_state <= c_ST_PIX_LO;
                                lcd_db  <= r_pix[7:0];
                                lcd_d_c <= 1'b1;
                                lcd_wr  <= 1'b0;
                            end
                            default: begin
                                // End of LO byte; a pending pop below
                                // overrides this with the next pixel.
                                r_state <= c_ST_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    r_state <= c_ST_RST_LOW;
                end
            endcase

            if (w_pop) begin
                r_pix  <= w_head[15:0];
                r_bcnt <= '0;
                lcd_wr <= 1'b0;
                if (w_head[16]) begin
                    r_state <= c_ST_RAMWR;
                    lcd_db  <= c_CMD_RAMWR;
                    lcd_d_c <= 1'b0;
                end else begin
                    r_state <= c_ST_PIX_HI;
                    lcd_db  <= w_head[15:8];
                    lcd_d_c <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_pixel_writer
// Purpose  : Directed self-checking bench for lcd_pixel_writer. Two DUT
//            copies share clock, reset and pixel fields: dut (2+2 cycle
//            bytes) and dut_s (8+2 cycle bytes, own pixel strobe) for the
//            FIFO overflow scenario. Bus monitors log each byte at the
//            lcd_wr rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_pixel_writer;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        pxl_en = 1'b0;
    logic        pxl_en_s = 1'b0;
    logic [10:0] pxl_x = '0;
    logic [10:0] pxl_y = '0;
    logic [3:0]  red_in = '0;
    logic [3:0]  green_in = '0;
    logic [3:0]  blue_in = '0;

    logic [7:0]  lcd_db, lcd_db_s;
    logic        lcd_wr, lcd_wr_s;
    logic        lcd_d_c, lcd_d_c_s;
    logic        lcd_rd, lcd_rd_s;
    logic        lcd_reset, lcd_reset_s;
    logic        init_done, init_done_s;
    logic        overflow, overflow_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lcd_pixel_writer #(
        .FIFO_DEPTH(16), .WR_LOW_CYC(2), .WR_HIGH_CYC(2), .RST_CYC(4), .WAKE_CYC(8)
    ) dut (
        .clk_100(clk), .resetN(resetN), .pxl_en(pxl_en), .pxl_x(pxl_x), .pxl_y(pxl_y),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .lcd_db(lcd_db), .lcd_wr(lcd_wr), .lcd_d_c(lcd_d_c), .lcd_rd(lcd_rd),
        .lcd_reset(lcd_reset), .init_done(init_done), .overflow(overflow)
    );

    lcd_pixel_writer #(
        .FIFO_DEPTH(16), .WR_LOW_CYC(8), .WR_HIGH_CYC(2), .RST_CYC(4), .WAKE_CYC(8)
    ) dut_s (
        .clk_100(clk), .resetN(resetN), .pxl_en(pxl_en_s), .pxl_x(pxl_x), .pxl_y(pxl_y),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .lcd_db(lcd_db_s), .lcd_wr(lcd_wr_s), .lcd_d_c(lcd_d_c_s), .lcd_rd(lcd_rd_s),
        .lcd_reset(lcd_reset_s), .init_done(init_done_s), .overflow(overflow_s)
    );

    // ------------------------------------------------------------------
    // Bus monitors: sample 1 time unit after each rising edge
    // ------------------------------------------------------------------
    logic [8:0] q_byte[$];
    int         q_low[$];
    bit         q_stable[$];
    int         q_fall[$];
    int         cyc = 0;
    bit         rd_bad = 1'b0;
    logic       m_prev = 1'b1;
    logic [8:0] m_fall_byte = '0;
    int         m_low = 0;
    bit         m_unstable = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (lcd_rd !== 1'b1) rd_bad = 1'b1;
        if (lcd_wr === 1'b0) begin
            if (m_prev !== 1'b0) begin
                m_fall_byte = {lcd_d_c, lcd_db};
                q_fall.push_back(cyc);
                m_low = 0;
                m_unstable = 1'b0;
            end
            m_low = m_low + 1;
            if ({lcd_d_c, lcd_db} !== m_fall_byte) m_unstable = 1'b1;
        end else if (lcd_wr === 1'b1 && m_prev === 1'b0) begin
            q_byte.push_back({lcd_d_c, lcd_db});
            q_low.push_back(m_low);
            q_stable.push_back(({lcd_d_c, lcd_db} === m_fall_byte) && !m_unstable);
        end
        m_prev = lcd_wr;
    end

    logic [8:0] q_byte_s[$];
    int         q_low_s[$];
    logic       s_prev = 1'b1;
    int         s_low = 0;

    always @(posedge clk) begin
        #1;
        if (lcd_wr_s === 1'b0) begin
            if (s_prev !== 1'b0) s_low = 0;
            s_low = s_low + 1;
        end else if (lcd_wr_s === 1'b1 && s_prev === 1'b0) begin
            q_byte_s.push_back({lcd_d_c_s, lcd_db_s});
            q_low_s.push_back(s_low);
        end
        s_prev = lcd_wr_s;
    end

    // Independent RGB444 -> RGB565 reference: {r,r3, g,g3,g2, b,b3}
    function automatic logic [15:0] rgb565(input logic [3:0] r, input logic [3:0] g,
                                           input logic [3:0] b);
        return {r, r[3], g, g[3:2], b, b[3]};
    endfunction

    // Drives one pixel strobe, 4-cycle period; entered and left on a negedge.
    task automatic send_pixel(input bit slow, input int x, input int y,
                              input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        pxl_x = 11'(x);
        pxl_y = 11'(y);
        red_in = r;
        green_in = g;
        blue_in = b;
        if (slow) pxl_en_s = 1'b1; else pxl_en = 1'b1;
        @(negedge clk);
        pxl_en = 1'b0;
        pxl_en_s = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int n;
        int base;
        int bad;
        logic [8:0] exp_init[4];
        exp_init = '{9'h011, 9'h03A, 9'h155, 9'h029};
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_reset, lcd_wr, lcd_d_c, lcd_rd, init_done, overflow, lcd_db} !== 14'b0_1_1_1_0_0_00000000) begin
            errors++;
            $display("FAIL reset_values: got reset=%b wr=%b dc=%b rd=%b done=%b ovf=%b db=%h, expected 0 1 1 1 0 0 00",
                     lcd_reset, lcd_wr, lcd_d_c, lcd_rd, init_done, overflow, lcd_db);
        end
        base = q_byte.size();
        resetN = 1'b1;
        n = 0;
        while (lcd_reset === 1'b0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL reset_low_len: lcd_reset low for %0d cycles, expected 4", n);
        end
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_timeout: init_done=%b after %0d cycles, expected 1", init_done, n);
        end
        checks++;
        if (q_byte.size() - base !== 4) begin
            errors++;
            $display("FAIL init_count: %0d bytes at init_done, expected 4", q_byte.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (((base + i) < q_byte.size() ? q_byte[base + i] : 9'h1FF) !== exp_init[i]) begin
                errors++;
                $display("FAIL init_byte%0d: got %h, expected %h", i,
                         ((base + i) < q_byte.size() ? q_byte[base + i] : 9'h1FF), exp_init[i]);
            end
        end
        bad = 0;
        for (int i = base; i < q_byte.size(); i++) begin
            if (q_low[i] != 2 || !q_stable[i]) bad++;
        end
        checks++;
        if (bad != 0 || q_byte.size() - base != 4) begin
            errors++;
            $display("FAIL init_byte_timing: %0d bytes with wrong low length or unstable bus, expected 0", bad);
        end
        checks++;
        if (q_fall.size() < 4 || (q_fall[q_fall.size()-1] - q_fall[q_fall.size()-2]) != 4 ||
            (q_fall[q_fall.size()-2] - q_fall[q_fall.size()-3]) != 4) begin
            errors++;
            $display("FAIL init_back_to_back: fall spacing not 4 cycles for data/cmd bytes");
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_sof_pixel();
        int base;
        base = q_byte.size();
        pxl_x = 11'd0;
        pxl_y = 11'd0;
        red_in = 4'hF;
        green_in = 4'h0;
        blue_in = 4'h0;
        pxl_en = 1'b1;
        @(negedge clk);
        pxl_en = 1'b0;
        checks++;
        if (lcd_wr !== 1'b1) begin
            errors++;
            $display("FAIL latency_early: lcd_wr=%b one cycle after strobe, expected 1", lcd_wr);
        end
        @(negedge clk);
        checks++;
        if (lcd_wr !== 1'b0 || lcd_d_c !== 1'b0 || lcd_db !== 8'h2C) begin
            errors++;
            $display("FAIL latency_launch: wr=%b dc=%b db=%h two cycles after strobe, expected 0 0 2c",
                     lcd_wr, lcd_d_c, lcd_db);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (q_byte.size() - base !== 3 ||
            q_byte[base] !== 9'h02C || q_byte[base+1] !== 9'h1F8 || q_byte[base+2] !== 9'h100) begin
            errors++;
            $display("FAIL sof_pixel_bytes: got %0d bytes, expected 02c 1f8 100", q_byte.size() - base);
        end
        checks++;
        if (rd_bad !== 1'b0) begin
            errors++;
            $display("FAIL lcd_rd_const: lcd_rd deviated from 1, expected constant 1");
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_discard();
        int base;
        base = q_byte.size();
        send_pixel(1'b0, 1, 0, 4'h5, 4'h5, 4'h5);
        send_pixel(1'b0, 2, 1, 4'h5, 4'h5, 4'h5);
        send_pixel(1'b0, 700, 0, 4'h5, 4'h5, 4'h5);
        repeat (16) @(negedge clk);
        checks++;
        if (q_byte.size() - base !== 0) begin
            errors++;
            $display("FAIL discard: %0d bytes written for dropped pixels, expected 0", q_byte.size() - base);
        end
        base = q_byte.size();
        send_pixel(1'b0, 2, 0, 4'h0, 4'hF, 4'hF);
        repeat (16) @(negedge clk);
        checks++;
        if (q_byte.size() - base !== 2 || q_byte[base] !== 9'h107 || q_byte[base+1] !== 9'h1FF) begin
            errors++;
            $display("FAIL plain_pixel: got %0d bytes, expected 107 1ff", q_byte.size() - base);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full_line();
        int base;
        int bad;
        int first_bad;
        int tbad;
        logic [8:0] exp[$];
        logic [10:0] xv;
        logic [15:0] p;
        base = q_byte.size();
        exp.push_back(9'h02C);
        for (int x = 0; x < 640; x++) begin
            xv = 11'(x);
            send_pixel(1'b0, x, 0, xv[4:1], xv[8:5], xv[3:0] ^ 4'hA);
            if (!xv[0]) begin
                p = rgb565(xv[4:1], xv[8:5], xv[3:0] ^ 4'hA);
                exp.push_back({1'b1, p[15:8]});
                exp.push_back({1'b1, p[7:0]});
            end
        end
        repeat (40) @(negedge clk);
        checks++;
        if (q_byte.size() - base !== 641) begin
            errors++;
            $display("FAIL line_len: %0d bytes, expected 641", q_byte.size() - base);
        end
        bad = 0;
        first_bad = -1;
        tbad = 0;
        for (int i = 0; i < 641; i++) begin
            if ((base + i) >= q_byte.size() || q_byte[base + i] !== exp[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end else if (q_low[base + i] != 2 || !q_stable[base + i]) begin
                tbad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL line_data: %0d wrong bytes (first at index %0d), expected 0", bad, first_bad);
        end
        checks++;
        if (tbad != 0) begin
            errors++;
            $display("FAIL line_timing: %0d bytes with bad strobe/hold, expected 0", tbad);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL line_overflow: overflow=%b, expected 0", overflow);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_overflow_burst();
        int n;
        int base;
        int bad;
        logic [8:0] exp[$];
        logic [3:0] kv;
        logic [15:0] p;
        n = 0;
        while (init_done_s !== 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (init_done_s !== 1'b1) begin
            errors++;
            $display("FAIL slow_init_timeout: init_done=%b, expected 1", init_done_s);
        end
        base = q_byte_s.size();
        // 23 kept pixels at one per 4 cycles against 20-cycle pixel writes:
        // pixels 20..22 meet a full FIFO, so only 0..19 reach the bus.
        exp.push_back(9'h02C);
        for (int k = 0; k < 23; k++) begin
            kv = 4'(k);
            send_pixel(1'b1, 2 * k, 0, kv, ~kv, kv + 4'd5);
            if (k < 20) begin
                p = rgb565(kv, ~kv, kv + 4'd5);
                exp.push_back({1'b1, p[15:8]});
                exp.push_back({1'b1, p[7:0]});
            end
        end
        checks++;
        if (overflow_s !== 1'b1) begin
            errors++;
            $display("FAIL burst_overflow: overflow=%b, expected 1", overflow_s);
        end
        repeat (600) @(negedge clk);
        checks++;
        if (q_byte_s.size() - base !== 41) begin
            errors++;
            $display("FAIL burst_len: %0d bytes, expected 41", q_byte_s.size() - base);
        end
        bad = 0;
        for (int i = 0; i < 41; i++) begin
            if ((base + i) >= q_byte_s.size() || q_byte_s[base + i] !== exp[i] ||
                q_low_s[base + i] != 8) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL burst_data: %0d wrong bytes or low lengths, expected 0", bad);
        end
        checks++;
        if (overflow_s !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_sticky: slow=%b main=%b, expected 1 0", overflow_s, overflow);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_pixel();
        int n;
        int base;
        send_pixel(1'b0, 0, 0, 4'h1, 4'h2, 4'h3);
        send_pixel(1'b0, 2, 0, 4'h4, 4'h5, 4'h6);
        send_pixel(1'b0, 4, 0, 4'h7, 4'h8, 4'h9);
        n = 0;
        while (lcd_wr !== 1'b0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (lcd_wr !== 1'b0) begin
            errors++;
            $display("FAIL midreset_wait: lcd_wr=%b, expected 0 during pixel write", lcd_wr);
        end
        resetN = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({lcd_wr, lcd_reset, init_done, lcd_d_c, lcd_db} !== 12'b1_0_0_1_00000000) begin
            errors++;
            $display("FAIL midreset_abort: wr=%b reset=%b done=%b dc=%b db=%h, expected 1 0 0 1 00",
                     lcd_wr, lcd_reset, init_done, lcd_d_c, lcd_db);
        end
        checks++;
        if (overflow_s !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: overflow=%b after reset, expected 0", overflow_s);
        end
        @(negedge clk);
        base = q_byte.size();
        @(negedge clk);
        resetN = 1'b1;
        n = 0;
        while ((init_done !== 1'b1 || init_done_s !== 1'b1) && n < 300) begin
            n++;
            @(negedge clk);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (q_byte.size() - base !== 4 || q_byte[base] !== 9'h011 || q_byte[base+1] !== 9'h03A ||
            q_byte[base+2] !== 9'h155 || q_byte[base+3] !== 9'h029) begin
            errors++;
            $display("FAIL midreset_reinit: %0d bytes after reset, expected exactly 011 03a 155 029",
                     q_byte.size() - base);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sof_pixel();
        test_discard();
        test_full_line();
        test_overflow_burst();
        test_reset_mid_pixel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
